// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// The arbiter lets the CPU and DMA ports share one single-ported data memory.
package mem_arb_pkg;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // FSM state encoding (legacy-compatible constants rather than an enum type)
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_sel_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin winner select.
// The output is purely combinational; the caller holds last_grant.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = cpu_req_i | dma_req_i;
    winner_o = REQ_CPU;
    if (cpu_req_i && dma_req_i) begin
      // On a tie the side not granted last time wins
      winner_o = (last_grant_i == REQ_DMA) ? REQ_CPU : REQ_DMA;
    end else if (dma_req_i) begin
      winner_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the data memory between CPU and DMA ports.
// One transaction at a time: IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [2:0]  DMA_FUNCT3  = FUNCT3_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [2:0]  cpu_funct3_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_ready_o,
  output logic [31:0] dma_rdata_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_funct3_o,
  input  logic [31:0] mem_rd_i,
  output logic        busy_o
);

  localparam int unsigned CntWRaw = $clog2(MEM_LATENCY + 1);
  localparam int unsigned CntW    = (CntWRaw < 1) ? 1 : CntWRaw;

  if (MEM_LATENCY == 0) begin : gen_latency_check
    $error("data_mem_arbiter: MEM_LATENCY must be at least 1");
  end

  state_t         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mem_req_t       req_q, req_d;
  req_sel_e       grant_q, grant_d;
  req_sel_e       last_grant_q, last_grant_d;
  logic [31:0]    rdata_q, rdata_d;

  logic arb_valid;
  logic arb_winner;

  rr_arbiter2 u_rr_arbiter2 (
    .cpu_req_i    (cpu_req_i),
    .dma_req_i    (dma_req_i),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = req_sel_e'(arb_winner);
          if (req_sel_e'(arb_winner) == REQ_DMA) begin
            req_d.we     = dma_we_i;
            req_d.addr   = dma_addr_i;
            req_d.wdata  = dma_wdata_i;
            req_d.funct3 = DMA_FUNCT3;
          end else begin
            req_d.we     = cpu_we_i;
            req_d.addr   = cpu_addr_i;
            req_d.wdata  = cpu_wdata_i;
            req_d.funct3 = cpu_funct3_i;
          end
          cnt_d   = CntW'(MEM_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rd_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      grant_q      <= REQ_DMA;
      last_grant_q <= REQ_DMA;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
    end
  end

  logic in_access;
  logic in_resp;

  always_comb begin
    in_access = (state_q == ACCESS);
    in_resp   = (state_q == RESP);

    mem_a_o      = in_access ? req_q.addr   : '0;
    mem_wd_o     = in_access ? req_q.wdata  : '0;
    mem_funct3_o = in_access ? req_q.funct3 : '0;
    // Single write strobe on the final access cycle
    mem_we_o     = in_access & req_q.we & (cnt_q == '0);

    cpu_ready_o = in_resp & (grant_q == REQ_CPU);
    dma_ready_o = in_resp & (grant_q == REQ_DMA);
    cpu_rdata_o = cpu_ready_o ? rdata_q : '0;
    dma_rdata_o = dma_ready_o ? rdata_q : '0;

    busy_o = (state_q != IDLE);
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter at latencies 1, 3 and 4.
// All three instances share one stimulus bus; each test reads only its instance.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rd;
  logic [2:0]  cpu_f3;

  logic        cpu_ready_1, dma_ready_1, mem_we_1, busy_1;
  logic [31:0] cpu_rdata_1, dma_rdata_1, mem_a_1, mem_wd_1;
  logic [2:0]  mem_f3_1;
  logic        cpu_ready_3, dma_ready_3, mem_we_3, busy_3;
  logic [31:0] cpu_rdata_3, dma_rdata_3, mem_a_3, mem_wd_3;
  logic [2:0]  mem_f3_3;
  logic        cpu_ready_4, dma_ready_4, mem_we_4, busy_4;
  logic [31:0] cpu_rdata_4, dma_rdata_4, mem_a_4, mem_wd_4;
  logic [2:0]  mem_f3_4;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_funct3_i(cpu_f3), .cpu_ready_o(cpu_ready_1), .cpu_rdata_o(cpu_rdata_1),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ready_o(dma_ready_1), .dma_rdata_o(dma_rdata_1),
    .mem_a_o(mem_a_1), .mem_wd_o(mem_wd_1), .mem_we_o(mem_we_1), .mem_funct3_o(mem_f3_1),
    .mem_rd_i(mem_rd), .busy_o(busy_1)
  );

  data_mem_arbiter #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_funct3_i(cpu_f3), .cpu_ready_o(cpu_ready_3), .cpu_rdata_o(cpu_rdata_3),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ready_o(dma_ready_3), .dma_rdata_o(dma_rdata_3),
    .mem_a_o(mem_a_3), .mem_wd_o(mem_wd_3), .mem_we_o(mem_we_3), .mem_funct3_o(mem_f3_3),
    .mem_rd_i(mem_rd), .busy_o(busy_3)
  );

  data_mem_arbiter #(.MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_funct3_i(cpu_f3), .cpu_ready_o(cpu_ready_4), .cpu_rdata_o(cpu_rdata_4),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ready_o(dma_ready_4), .dma_rdata_o(dma_rdata_4),
    .mem_a_o(mem_a_4), .mem_wd_o(mem_wd_4), .mem_we_o(mem_we_4), .mem_funct3_o(mem_f3_4),
    .mem_rd_i(mem_rd), .busy_o(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_f3    = 3'b000;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    mem_rd    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int we_cnt;
  int ready_cnt;

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state: every output of every instance is zero
    check_eq("reset_outputs_zero",
             32'({cpu_ready_1, dma_ready_1, mem_we_1, busy_1, mem_f3_1} != 0) |
             32'((cpu_rdata_1 | dma_rdata_1 | mem_a_1 | mem_wd_1) != 0) |
             32'({cpu_ready_3, dma_ready_3, mem_we_3, busy_3, mem_f3_3} != 0) |
             32'((cpu_rdata_3 | dma_rdata_3 | mem_a_3 | mem_wd_3) != 0) |
             32'({cpu_ready_4, dma_ready_4, mem_we_4, busy_4, mem_f3_4} != 0) |
             32'((cpu_rdata_4 | dma_rdata_4 | mem_a_4 | mem_wd_4) != 0), 32'd0);

    // Test 1: CPU load, latency 1
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_f3 = 3'b010;
    mem_rd = 32'hDEAD_BEEF;
    check_eq("t1_c0_busy", 32'(busy_1), 32'd0);
    step();
    check_eq("t1_c1_busy", 32'(busy_1), 32'd1);
    check_eq("t1_c1_ready", 32'(cpu_ready_1), 32'd0);
    check_eq("t1_c1_addr", mem_a_1, 32'h10);
    step();
    check_eq("t1_c2_ready", 32'(cpu_ready_1), 32'd1);
    check_eq("t1_c2_rdata", cpu_rdata_1, 32'hDEAD_BEEF);
    check_eq("t1_c2_dma_ready", 32'(dma_ready_1), 32'd0);
    check_eq("t1_c2_busy", 32'(busy_1), 32'd1);
    cpu_req = 1'b0;
    step();
    check_eq("t1_c3_busy", 32'(busy_1), 32'd0);
    check_eq("t1_c3_ready", 32'(cpu_ready_1), 32'd0);
    check_eq("t1_c3_rdata", cpu_rdata_1, 32'd0);

    // Test 2: DMA write, latency 3
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h0000_00A5;
    we_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (mem_we_3) we_cnt++;
      if (c == 3) begin
        check_eq("t2_c3_we", 32'(mem_we_3), 32'd1);
        check_eq("t2_c3_wd", mem_wd_3, 32'h0000_00A5);
        dma_req = 1'b0;
      end
      if (c == 1) begin
        check_eq("t2_c1_addr", mem_a_3, 32'h20);
        check_eq("t2_c1_f3", 32'(mem_f3_3), 32'd2);
      end
      check_eq("t2_dma_ready", 32'(dma_ready_3), (c == 4) ? 32'd1 : 32'd0);
      check_eq("t2_cpu_ready", 32'(cpu_ready_3), 32'd0);
    end
    check_eq("t2_we_once", 32'(we_cnt), 32'd1);
    check_eq("t2_end_busy", 32'(busy_3), 32'd0);

    // Test 3: both requesting continuously, latency 1 -> alternate CPU, DMA
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h100; cpu_f3 = 3'b010;
    dma_req = 1'b1; dma_addr = 32'h200;
    for (int c = 1; c <= 12; c++) begin
      step();
      check_eq("t3_cpu_ready", 32'(cpu_ready_1),
               ((c % 3 == 2) && ((c / 3) % 2 == 0)) ? 32'd1 : 32'd0);
      check_eq("t3_dma_ready", 32'(dma_ready_1),
               ((c % 3 == 2) && ((c / 3) % 2 == 1)) ? 32'd1 : 32'd0);
      if (c % 3 == 1)
        check_eq("t3_addr", mem_a_1, ((c / 3) % 2 == 0) ? 32'h100 : 32'h200);
    end
    clear_inputs();

    // Test 4: CPU sb with address changed after grant, latency 3
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_f3 = 3'b000; cpu_wdata = 32'h77;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) cpu_addr = 32'h44;
      if (c <= 3) begin
        check_eq("t4_addr", mem_a_3, 32'h40);
        check_eq("t4_f3", 32'(mem_f3_3), 32'd0);
      end
    end
    check_eq("t4_ready", 32'(cpu_ready_3), 32'd1);
    clear_inputs();

    // Test 5: reset mid-ACCESS of a DMA store, latency 4
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h50; cpu_f3 = 3'b010;
    for (int c = 1; c <= 5; c++) step();
    check_eq("t5_cpu_ready", 32'(cpu_ready_4), 32'd1);
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h55;
    step();
    check_eq("t5_idle_gap", 32'(busy_4), 32'd0);
    step();
    step();
    check_eq("t5_pre_addr", mem_a_4, 32'h30);
    check_eq("t5_pre_we", 32'(mem_we_4), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_we", 32'(mem_we_4), 32'd0);
    check_eq("t5_rst_busy", 32'(busy_4), 32'd0);
    check_eq("t5_rst_addr", mem_a_4, 32'd0);
    ready_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (dma_ready_4 || mem_we_4) ready_cnt++;
    end
    check_eq("t5_no_ready", 32'(ready_cnt), 32'd0);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0;
    step();
    check_eq("t5_cpu_first_addr", mem_a_4, 32'h50);
    check_eq("t5_cpu_first_we", 32'(mem_we_4), 32'd0);
    for (int c = 2; c <= 5; c++) step();
    check_eq("t5_post_cpu_ready", 32'(cpu_ready_4), 32'd1);
    check_eq("t5_post_dma_ready", 32'(dma_ready_4), 32'd0);
    clear_inputs();

    // Test 6: CPU drops req during ACCESS, latency 3
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h8; cpu_f3 = 3'b010; mem_rd = 32'h1234_5678;
    ready_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) cpu_req = 1'b0;
      if (cpu_ready_3) ready_cnt++;
      if (c == 4) check_eq("t6_rdata", cpu_rdata_3, 32'h1234_5678);
      if (c >= 5) check_eq("t6_idle_busy", 32'(busy_3), 32'd0);
    end
    check_eq("t6_ready_once", 32'(ready_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-ported data memory between two requesters:
  - the CPU load/store port, driven by the execute/memory stage;
  - a DMA/loader port, used by test and boot code to preload or dump memory.
- Two-requester round-robin grant, one transaction at a time.
- Drives the memory address, write data, write enable and funct3 for a configurable number of cycles, then returns read data with a one-cycle ready pulse.
- Sits between the core and the data memory; the memory instance's port list is unchanged.

Parameters:
- MEM_LATENCY, 1, cycles the memory address/data are held before read data is captured; must be >= 1, elaboration error if 0.
- DMA_FUNCT3, 3'b010, access size used for all DMA transactions (word).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_req_i  input  1  CPU access request, level, held until cpu_ready_o
- cpu_we_i  input  1  1 = store, 0 = load
- cpu_addr_i  input  32  byte address
- cpu_wdata_i  input  32  store data
- cpu_funct3_i  input  3  access size/sign (lb/lh/lw/lbu/lhu/sb/sh/sw encoding)
- cpu_ready_o  output  1  one-cycle completion pulse
- cpu_rdata_o  output  32  load data, valid while cpu_ready_o = 1
- dma_req_i  input  1  DMA request, level
- dma_we_i  input  1  1 = write
- dma_addr_i  input  32  byte address
- dma_wdata_i  input  32  write data
- dma_ready_o  output  1  one-cycle completion pulse
- dma_rdata_o  output  32  read data, valid while dma_ready_o = 1
- mem_a_o  output  32  memory address
- mem_wd_o  output  32  memory write data
- mem_we_o  output  1  memory write enable
- mem_funct3_o  output  3  memory access size
- mem_rd_i  input  32  memory read data
- busy_o  output  1  1 when state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is high, pick the winner, latch its we/addr/wdata/funct3 (DMA uses DMA_FUNCT3), load cnt = MEM_LATENCY-1, and go to ACCESS.
  - If no request is high, stay in IDLE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requests high, the requester not granted last wins.
  - last_grant resets to DMA, so the CPU wins the first tie.
  - Neither side waits more than one foreign transaction.
- ACCESS:
  - mem_a_o/mem_wd_o/mem_funct3_o driven from the latched values.
  - cnt decrements each cycle.
  - When cnt == 0: capture mem_rd_i into rdata_q, go to RESP.
  - mem_we_o = latched_we AND (cnt == 0), so a store produces exactly one write edge per transaction.
- RESP:
  - The granted side's ready_o = 1 for exactly one cycle, with rdata_o = rdata_q (rdata is also returned for stores; the value is don't-care but deterministic).
  - last_grant is updated here.
  - Next state is IDLE.
- Timing:
  - Request sampled in IDLE at cycle 0.
  - ACCESS occupies cycles 1..MEM_LATENCY.
  - ready at cycle MEM_LATENCY+1.
  - Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- Handshake:
  - The requester holds req and payload stable until ready.
  - Payload changes after grant are ignored, since the payload is latched.
  - Deasserting req mid-transaction does not abort it; the ready pulse is still issued.
  - A req still high in the cycle after ready counts as a new request.
- Idle outputs: mem_a_o = 0, mem_wd_o = 0, mem_we_o = 0, mem_funct3_o = 0, both ready_o = 0, both rdata_o = 0 (outputs are gated by the granted side).
- Reset:
  - Asserting rst at any time forces IDLE, cnt = 0, rdata_q = 0, last_grant = DMA.
  - All outputs go to 0 immediately, including mem_we_o, so no partial write occurs after reset assertion.
  - An in-flight transaction is dropped with no ready.
- Counter width: $clog2(MEM_LATENCY+1), minimum 1 bit.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the requester enum (REQ_CPU, REQ_DMA);
  - a FUNCT3_WORD = 3'b010 constant;
  - a packed mem_req_t struct (we, addr, wdata, funct3).
- One sub-module, rr_arbiter2: combinational winner from two requests plus the last_grant input.
- FSM, counter and latches stay in the top.

Test Plan:
- Reset, then CPU load from 0x10 with memory word 0xDEADBEEF, MEM_LATENCY=1 -> cpu_ready_o at cycle 2, cpu_rdata_o = 0xDEADBEEF, dma_ready_o stays 0, busy_o high for cycles 1-2.
- DMA write 0x0000_00A5 to 0x20 with MEM_LATENCY=3 -> mem_we_o high for exactly one cycle (cycle 3), mem_a_o = 0x20, mem_funct3_o = 3'b010, dma_ready_o at cycle 4.
- CPU and DMA both held high continuously after reset -> grants alternate CPU, DMA, CPU, DMA; each ready spaced MEM_LATENCY+2 cycles apart.
- CPU sb (funct3 3'b000) with cpu_addr_i changed to 0x44 one cycle after grant from 0x40 -> memory sees 0x40 and funct3 3'b000 throughout ACCESS.
- rst asserted mid-ACCESS of a DMA store (MEM_LATENCY=4, cnt=2) -> mem_we_o 0 from assertion, no ready pulse, busy_o 0; the next CPU request after release is granted first.
- CPU req dropped during ACCESS -> cpu_ready_o still pulses once; FSM returns to IDLE and stays there with no requests.
